id_scoreboard: RTL and testbench
================================

// Module: id_scoreboard
// PURPOSE
//  Issue controller for the ID stage. Tracks which architectural registers have a write in flight,
//  stalls ID on RAW/WAW hazards and when in-flight capacity is full, and sequences pipeline flushes
//  after a PC redirect. Sits beside the decode stage: decode feeds it, it drives the stall/flush controls.
// PARAMETERS
//  MaxInFlight  4   max issued, not-yet-written-back register writes (1..15)
//  FlushCycles  2   cycles oFlush stays high after a redirect (>=1)
// PORTS
//  iClk         in   1             clock; all state updates on rising edge
//  iRst         in   1             synchronous reset, active-high
//  iIssueValid  in   1             decoded instruction is present in ID
//  iAddrRs1     in   RegAddrWidth  source 1 address
//  iAddrRs2     in   RegAddrWidth  source 2 address
//  iUseRs1      in   1             instruction reads rs1
//  iUseRs2      in   1             instruction reads rs2
//  iAddrRd      in   RegAddrWidth  destination address
//  iWriteRd     in   1             instruction writes rd
//  iWbValid     in   1             writeback this cycle
//  iWbAddrRd    in   RegAddrWidth  writeback destination
//  iRedirect    in   1             PC redirect (branch/jump taken)
//  oStall       out  1             hold IF/ID, inject bubble into EX
//  oIssue       out  1             instruction accepted this cycle
//  oFlush       out  1             squash IF/ID contents
//  oBusy        out  NumRegs       pending-write bitmap; bit 0 always 0
//  oInFlight    out  4             number of outstanding writes
//  oErr         out  1             sticky: writeback with no pending write
// BEHAVIOUR
//  Reset: oBusy=0, oInFlight=0, oErr=0, oFlush=0, FSM=SB_RUN. oStall/oIssue are combinational from state.
//  hazard = iUseRs1 && rs1!=0 && busy[rs1] || iUseRs2 && rs2!=0 && busy[rs2]
//           || iWriteRd && rd!=0 && busy[rd] (WAW) || iWriteRd && oInFlight==MaxInFlight.
//  oStall = iIssueValid && hazard && state==SB_RUN.  oIssue = iIssueValid && !hazard && state==SB_RUN.
//  Issue writing rd!=0: busy[rd] set and oInFlight+1 at next edge. rd==0 or !iWriteRd: no state change.
//  Writeback: busy[iWbAddrRd] cleared and oInFlight-1 when that bit was set. If the bit was clear,
//   or iWbAddrRd==0: no change; oErr set if iWbAddrRd!=0. oInFlight never underflows.
//  Same-cycle issue(rd=X) + writeback(X): the WAW stall blocks the issue, so set/clear never collide.
//   Issue and writeback to different registers in one cycle: oInFlight net unchanged.
//  FSM (rv32_isa::sb_state_e): SB_RUN --iRedirect--> SB_FLUSH, load counter=FlushCycles-1.
//   SB_FLUSH: oFlush=1, no issue, no stall, counter decrements each cycle. Counter==0 -> SB_RUN.
//   iRedirect while in SB_FLUSH reloads the counter (flush is extended).
//   oFlush is registered: high from the cycle after iRedirect for exactly FlushCycles cycles.
//  Writebacks are processed in every state. Pending bits survive a flush, because squashed
//   instructions were never issued.
//  iRst mid-operation clears all busy bits and the counter; the bench drains or discards EX/MEM/WB.
//  Latency: hazard decision is 0 cycles (combinational). Busy update is 1 cycle.
// CONFIGURATION
//  SCOREBOARD_FWD_EN defined: a source hazard on register X is waived when iWbValid && iWbAddrRd==X
//   this cycle. Extra outputs oFwdRs1/oFwdRs2 (1 bit each) select the writeback data over the
//   register file. The WAW check is unchanged.
//  Not defined: no forwarding ports; the instruction stalls until the cycle after writeback
//   (register file is write-then-read across the edge).
// STRUCTURE
//  rv32_isa package: RegAddrWidth, NumRegs=2**RegAddrWidth, typedef enum logic {SB_RUN,SB_FLUSH} sb_state_e.
//  Sub-module sb_flush_fsm: state register, reload counter, oFlush.
//   The busy bitmap, in-flight counter and hazard logic live in id_scoreboard.
// TESTING
//  1. Issue x5 write, then the next op reads x5 -> oStall=1 until the cycle after WB(x5), then oIssue=1.
//     With FWD_EN: no stall in the WB cycle, oFwdRs1=1.
//  2. Issue writes to x1,x2,x3,x4 with no WB -> oInFlight=4; write x6 -> oStall=1.
//     WB x1 -> x6 issues the next cycle, oInFlight stays 4.
//  3. Issue op with rd=x0 and a read of x0 -> oIssue=1, oBusy=0, oInFlight=0.
//  4. iRedirect at cycle t -> oFlush=1 at t+1..t+2, oIssue=0 in those cycles.
//     Redirect again at t+1 -> oFlush held through t+3.
//  5. WB x9 with x9 not busy -> oErr=1 (sticky), oInFlight unchanged. iRst=1 -> oErr=0, oBusy=0.
//  6. WB x2 and issue with rd=x7 in the same cycle -> busy[2]=0, busy[7]=1, oInFlight unchanged.

Source files
------------

// File: rtl/rv32_isa_pkg.sv
// Shared ISA-level definitions for the ID-stage issue logic.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the register address width, the register count and the
// scoreboard flush-FSM state encoding.
package rv32_isa;

  localparam int RegAddrWidth = 5;
  localparam int NumRegs      = 2 ** RegAddrWidth;

  typedef logic [RegAddrWidth-1:0] reg_addr_t;

  typedef enum logic {
    SB_RUN   = 1'b0,
    SB_FLUSH = 1'b1
  } sb_state_e;

endpackage

// File: rtl/sb_flush_fsm.sv
// Flush sequencer: holds oFlush high for FlushCycles cycles after a PC redirect.
// Latency: oFlush rises the cycle after iRedirect; a redirect during a flush restarts the count.
// Backpressure: none; iRedirect is always accepted.
//
// Ports:
//   iClk, iRst  clock, synchronous active-high reset
//   iRedirect   PC redirect (branch/jump taken)
//   oState      SB_RUN while issue is allowed, SB_FLUSH while squashing
//   oFlush      registered squash control for IF/ID
module sb_flush_fsm
  import rv32_isa::*;
#(
  parameter int FlushCycles = 2
) (
  input  logic      iClk,
  input  logic      iRst,
  input  logic      iRedirect,
  output sb_state_e oState,
  output logic      oFlush
);

  localparam int CntW = (FlushCycles > 1) ? $clog2(FlushCycles) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(FlushCycles - 1);

  // Counts remaining flush cycles after the current one.
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oState <= SB_RUN;
      cnt_q  <= '0;
      oFlush <= 1'b0;
    end else begin
      case (oState)
        SB_RUN: begin
          if (iRedirect) begin
            oState <= SB_FLUSH;
            cnt_q  <= CntLoad;
            oFlush <= 1'b1;
          end
        end
        SB_FLUSH: begin
          if (iRedirect) begin
            // A younger redirect extends the squash window.
            cnt_q  <= CntLoad;
            oFlush <= 1'b1;
          end else if (cnt_q == '0) begin
            oState <= SB_RUN;
            oFlush <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/id_scoreboard.sv
// ID-stage issue controller: pending-write scoreboard, RAW/WAW/capacity stall, redirect flush.
// Latency: stall/issue decision is combinational (0 cycles); busy bitmap and counters update in 1 cycle.
// Backpressure: oStall holds IF/ID on a hazard or when MaxInFlight writes are outstanding.
//
// Optional feature: define SCOREBOARD_FWD_EN to waive a source hazard whose register is being
// written back this cycle; oFwdRs1/oFwdRs2 then select the writeback data over the register file.
//
// Ports:
//   iClk, iRst                 clock, synchronous active-high reset
//   iIssueValid                decoded instruction present in ID
//   iAddrRs1/iAddrRs2          source addresses, qualified by iUseRs1/iUseRs2
//   iAddrRd, iWriteRd          destination address and write enable
//   iWbValid, iWbAddrRd        writeback this cycle and its destination
//   iRedirect                  PC redirect
//   oStall, oIssue, oFlush     pipeline controls
//   oBusy                      pending-write bitmap (bit 0 always 0)
//   oInFlight                  outstanding write count
//   oErr                       sticky: writeback to a non-pending register
//   oFwdRs1/oFwdRs2            (SCOREBOARD_FWD_EN only) forward writeback data to rs1/rs2
module id_scoreboard
  import rv32_isa::*;
#(
  parameter int MaxInFlight = 4,
  parameter int FlushCycles = 2
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iIssueValid,
  input  reg_addr_t          iAddrRs1,
  input  reg_addr_t          iAddrRs2,
  input  logic               iUseRs1,
  input  logic               iUseRs2,
  input  reg_addr_t          iAddrRd,
  input  logic               iWriteRd,
  input  logic               iWbValid,
  input  reg_addr_t          iWbAddrRd,
  input  logic               iRedirect,
  output logic               oStall,
  output logic               oIssue,
  output logic               oFlush,
  output logic [NumRegs-1:0] oBusy,
  output logic [3:0]         oInFlight,
  output logic               oErr
`ifdef SCOREBOARD_FWD_EN
  ,
  output logic               oFwdRs1,
  output logic               oFwdRs2
`endif
);

  sb_state_e          state;
  logic [NumRegs-1:0] busy_q;
  logic [NumRegs-1:0] busy_d;
  logic [3:0]         in_flight_q;
  logic               err_q;

  logic rs1_pend, rs2_pend;
  logic rs1_haz, rs2_haz, waw_haz, full_haz, hazard;
  logic run;
  logic issue_wr, wb_hit, wb_err;

  sb_flush_fsm #(
    .FlushCycles(FlushCycles)
  ) u_flush_fsm (
    .iClk     (iClk),
    .iRst     (iRst),
    .iRedirect(iRedirect),
    .oState   (state),
    .oFlush   (oFlush)
  );

  // x0 is never tracked, so a read of x0 can never be pending.
  assign rs1_pend = iUseRs1 && (iAddrRs1 != '0) && busy_q[iAddrRs1];
  assign rs2_pend = iUseRs2 && (iAddrRs2 != '0) && busy_q[iAddrRs2];

`ifdef SCOREBOARD_FWD_EN
  // A pending source whose write lands this cycle is served from the writeback bus.
  assign oFwdRs1 = rs1_pend && iWbValid && (iWbAddrRd == iAddrRs1);
  assign oFwdRs2 = rs2_pend && iWbValid && (iWbAddrRd == iAddrRs2);
  assign rs1_haz = rs1_pend && !oFwdRs1;
  assign rs2_haz = rs2_pend && !oFwdRs2;
`else
  // Register file is write-then-read across the edge: wait until the cycle after writeback.
  assign rs1_haz = rs1_pend;
  assign rs2_haz = rs2_pend;
`endif

  // WAW is never waived, which also keeps a same-cycle set and clear of one bit impossible.
  assign waw_haz  = iWriteRd && (iAddrRd != '0) && busy_q[iAddrRd];
  // Capacity uses the registered count, so a same-cycle writeback does not free a slot yet.
  assign full_haz = iWriteRd && (in_flight_q == 4'(MaxInFlight));
  assign hazard   = rs1_haz || rs2_haz || waw_haz || full_haz;

  assign run    = (state == SB_RUN);
  assign oStall = iIssueValid && hazard && run;
  assign oIssue = iIssueValid && !hazard && run;

  assign issue_wr = oIssue && iWriteRd && (iAddrRd != '0);
  assign wb_hit   = iWbValid && (iWbAddrRd != '0) && busy_q[iWbAddrRd];
  assign wb_err   = iWbValid && (iWbAddrRd != '0) && !busy_q[iWbAddrRd];

  always_comb begin
    busy_d = busy_q;
    if (wb_hit) begin
      busy_d[iWbAddrRd] = 1'b0;
    end
    if (issue_wr) begin
      busy_d[iAddrRd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      busy_q      <= '0;
      in_flight_q <= '0;
      err_q       <= 1'b0;
    end else begin
      busy_q <= busy_d;
      // wb_hit implies a set busy bit, hence a non-zero count: no underflow possible.
      if (issue_wr && !wb_hit) begin
        in_flight_q <= in_flight_q + 4'd1;
      end else if (!issue_wr && wb_hit) begin
        in_flight_q <= in_flight_q - 4'd1;
      end
      if (wb_err) begin
        err_q <= 1'b1;
      end
    end
  end

  assign oBusy     = busy_q;
  assign oInFlight = in_flight_q;
  assign oErr      = err_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed self-checking bench for id_scoreboard (MaxInFlight=4, FlushCycles=2).
// Inputs change 1 time unit after a rising edge; outputs are sampled before the next edge.
module tb_id_scoreboard;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  addr_rs1;
  logic [4:0]  addr_rs2;
  logic        use_rs1;
  logic        use_rs2;
  logic [4:0]  addr_rd;
  logic        write_rd;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic        redirect;
  logic        stall;
  logic        issue;
  logic        flush;
  logic [31:0] busy;
  logic [3:0]  in_flight;
  logic        err;
`ifdef SCOREBOARD_FWD_EN
  logic        fwd_rs1;
  logic        fwd_rs2;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  id_scoreboard #(
    .MaxInFlight(4),
    .FlushCycles(2)
  ) dut (
    .iClk       (clk),
    .iRst       (rst),
    .iIssueValid(issue_valid),
    .iAddrRs1   (addr_rs1),
    .iAddrRs2   (addr_rs2),
    .iUseRs1    (use_rs1),
    .iUseRs2    (use_rs2),
    .iAddrRd    (addr_rd),
    .iWriteRd   (write_rd),
    .iWbValid   (wb_valid),
    .iWbAddrRd  (wb_addr),
    .iRedirect  (redirect),
    .oStall     (stall),
    .oIssue     (issue),
    .oFlush     (flush),
    .oBusy      (busy),
    .oInFlight  (in_flight),
    .oErr       (err)
`ifdef SCOREBOARD_FWD_EN
    ,
    .oFwdRs1    (fwd_rs1),
    .oFwdRs2    (fwd_rs2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    addr_rs1    = '0;
    addr_rs2    = '0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    addr_rd     = '0;
    write_rd    = 1'b0;
    wb_valid    = 1'b0;
    wb_addr     = '0;
    redirect    = 1'b0;
  endtask

  task automatic op(input logic [4:0] rs1, input logic u1, input logic [4:0] rd, input logic w);
    issue_valid = 1'b1;
    addr_rs1    = rs1;
    use_rs1     = u1;
    addr_rs2    = '0;
    use_rs2     = 1'b0;
    addr_rd     = rd;
    write_rd    = w;
  endtask

  task automatic wb(input logic [4:0] a);
    wb_valid = 1'b1;
    wb_addr  = a;
  endtask

  task automatic drain(input logic [4:0] a);
    idle();
    wb(a);
    tick();
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_busy", busy, 32'h0);
    check("rst_inflight", 32'(in_flight), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_issue", 32'(issue), 32'd0);

    // 1: RAW on x5
    op(5'd0, 1'b0, 5'd5, 1'b1);
    #1;
    check("t1_issue_x5", 32'(issue), 32'd1);
    tick();
    op(5'd5, 1'b1, 5'd6, 1'b1);
    #1;
    check("t1_raw_stall", 32'(stall), 32'd1);
    check("t1_raw_no_issue", 32'(issue), 32'd0);
    check("t1_busy_x5", busy, 32'h0000_0020);
    check("t1_inflight", 32'(in_flight), 32'd1);
    tick();
    wb(5'd5);
    #1;
`ifdef SCOREBOARD_FWD_EN
    check("t1_fwd_no_stall", 32'(stall), 32'd0);
    check("t1_fwd_issue", 32'(issue), 32'd1);
    check("t1_fwd_rs1", 32'(fwd_rs1), 32'd1);
    tick();
    idle();
`else
    check("t1_stall_wb_cycle", 32'(stall), 32'd1);
    tick();
    wb_valid = 1'b0;
    #1;
    check("t1_issue_after_wb", 32'(issue), 32'd1);
    tick();
    idle();
`endif
    #1;
    check("t1_busy_x6", busy, 32'h0000_0040);
    check("t1_inflight_end", 32'(in_flight), 32'd1);
    drain(5'd6);
    #1;
    check("t1_drained", 32'(in_flight), 32'd0);

    // 2: capacity limit
    for (int i = 1; i <= 4; i++) begin
      op(5'd0, 1'b0, 5'(i), 1'b1);
      #1;
      check("t2_issue_fill", 32'(issue), 32'd1);
      tick();
    end
    idle();
    #1;
    check("t2_inflight_full", 32'(in_flight), 32'd4);
    check("t2_busy_full", busy, 32'h0000_001E);
    op(5'd0, 1'b0, 5'd6, 1'b1);
    #1;
    check("t2_full_stall", 32'(stall), 32'd1);
    tick();
    wb(5'd1);
    #1;
    check("t2_full_stall_wb_cycle", 32'(stall), 32'd1);
    tick();
    wb_valid = 1'b0;
    #1;
    check("t2_inflight_after_wb", 32'(in_flight), 32'd3);
    check("t2_issue_after_wb", 32'(issue), 32'd1);
    tick();
    idle();
    #1;
    check("t2_inflight_end", 32'(in_flight), 32'd4);
    check("t2_busy_end", busy, 32'h0000_005C);

    // 6: writeback and issue to different registers in one cycle
    drain(5'd6);
    #1;
    check("t6_inflight_pre", 32'(in_flight), 32'd3);
    op(5'd0, 1'b0, 5'd7, 1'b1);
    wb(5'd2);
    #1;
    check("t6_issue", 32'(issue), 32'd1);
    tick();
    idle();
    #1;
    check("t6_busy", busy, 32'h0000_0098);
    check("t6_inflight", 32'(in_flight), 32'd3);
    op(5'd0, 1'b0, 5'd0, 1'b0);
    use_rs2  = 1'b1;
    addr_rs2 = 5'd7;
    #1;
    check("t6_rs2_raw_stall", 32'(stall), 32'd1);
    drain(5'd3);
    drain(5'd4);
    drain(5'd7);
    #1;
    check("t6_drained_busy", busy, 32'h0);
    check("t6_drained_inflight", 32'(in_flight), 32'd0);

    // 3: x0 is never tracked
    op(5'd0, 1'b1, 5'd0, 1'b1);
    #1;
    check("t3_issue_x0", 32'(issue), 32'd1);
    tick();
    idle();
    #1;
    check("t3_busy_x0", busy, 32'h0);
    check("t3_inflight_x0", 32'(in_flight), 32'd0);

    // 4: redirect flush, x8 pending so a read would otherwise stall
    op(5'd0, 1'b0, 5'd8, 1'b1);
    tick();
    idle();
    redirect = 1'b1;
    #1;
    check("t4_flush_t", 32'(flush), 32'd0);
    tick();
    redirect = 1'b0;
    op(5'd8, 1'b1, 5'd0, 1'b0);
    #1;
    check("t4_flush_t1", 32'(flush), 32'd1);
    check("t4_issue_t1", 32'(issue), 32'd0);
    check("t4_stall_t1", 32'(stall), 32'd0);
    tick();
    #1;
    check("t4_flush_t2", 32'(flush), 32'd1);
    check("t4_issue_t2", 32'(issue), 32'd0);
    tick();
    #1;
    check("t4_flush_t3", 32'(flush), 32'd0);
    check("t4_stall_t3", 32'(stall), 32'd1);
    check("t4_busy_survives", busy, 32'h0000_0100);
    idle();
    redirect = 1'b1;
    tick();
    #1;
    check("t4b_flush_t1", 32'(flush), 32'd1);
    tick();
    redirect = 1'b0;
    wb(5'd8);
    #1;
    check("t4b_flush_t2", 32'(flush), 32'd1);
    tick();
    idle();
    #1;
    check("t4b_flush_t3", 32'(flush), 32'd1);
    check("t4b_wb_in_flush", busy, 32'h0);
    tick();
    #1;
    check("t4b_flush_t4", 32'(flush), 32'd0);

    // 5: spurious writeback, sticky error, reset
    op(5'd0, 1'b0, 5'd10, 1'b1);
    tick();
    idle();
    wb(5'd0);
    tick();
    idle();
    #1;
    check("t5_wb_x0_no_err", 32'(err), 32'd0);
    wb(5'd9);
    tick();
    idle();
    #1;
    check("t5_err_set", 32'(err), 32'd1);
    check("t5_inflight_kept", 32'(in_flight), 32'd1);
    check("t5_busy_kept", busy, 32'h0000_0400);
    tick();
    #1;
    check("t5_err_sticky", 32'(err), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("t5_rst_err", 32'(err), 32'd0);
    check("t5_rst_busy", busy, 32'h0);
    check("t5_rst_inflight", 32'(in_flight), 32'd0);
    op(5'd0, 1'b0, 5'd3, 1'b1);
    #1;
    check("t5_issue_after_rst", 32'(issue), 32'd1);
    tick();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
